pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hold/flush scheduler for the three-stage core pipeline (pc_reg → if_id → id_ex → ex). It merges hold and flush requests from four sources into the single `hold_flag_o` level that every pipeline register compares against:
- ex-stage jumps
- multi-cycle ex operations
- load-use hazards
- interrupt controller

It also arbitrates the instruction/data bus between the core and an external bus master (debugger/DMA), and keeps a free-running stall-cycle counter.

## Interface
Parameters:
- JUMP_FLUSH_CYCLES, 1, extra cycles after a jump cycle during which Hold_Id stays asserted (covers synchronous-ROM fetch latency); legal range 0-7.
- DRAIN_CYCLES, 2, cycles of Hold_Pc before the bus grant, letting in-flight fetch/access retire; legal range 1-7.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_i  in  1  ex requests jump/branch taken.
- jump_addr_i  in  32  jump target.
- hold_ex_i  in  1  ex multi-cycle op busy (divider etc.).
- hold_clint_i  in  1  interrupt controller requests pipeline hold.
- ex_load_i  in  1  instruction in ex is a load.
- ex_rd_i  in  5  ex destination register.
- id_rs1_i, id_rs2_i  in  5 each  id source registers.
- id_rs1_used_i, id_rs2_used_i  in  1 each  id instruction reads rs1/rs2.
- bus_req_i  in  1  external master bus request (level).
- cnt_clr_i  in  1  synchronous clear of stall counter.
- hold_flag_o  out  3  Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
- jump_flag_o  out  1  jump to pc_reg.
- jump_addr_o  out  32  jump target to pc_reg.
- bus_gnt_o  out  1  bus granted to external master.
- stall_cnt_o  out  32  cycles with hold_flag_o != 0.

## Operation
- FSM states: RUN, JFLUSH, DRAIN, OWN. Reset state is RUN.
- The following are combinational, same cycle:
  - jump_flag_o = jump_flag_i and jump_addr_o = jump_addr_i.
  - Load-use hit = ex_load_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- hold_flag_o = maximum of all active contributions:
  - Hold_Id: jump_flag_i, state JFLUSH, hold_ex_i, hold_clint_i, load-use hit.
  - Hold_Pc: state DRAIN or OWN.
- RUN:
  - jump_flag_i → JFLUSH, flush counter loaded with JUMP_FLUSH_CYCLES. If JUMP_FLUSH_CYCLES=0, stay in RUN.
  - Otherwise, bus_req_i & ~hold_ex_i → DRAIN, drain counter loaded with DRAIN_CYCLES.
  - Jump has priority over bus_req_i in the same cycle.
- JFLUSH:
  - Counter decrements each cycle; the cycle it reads 1, next state is RUN.
  - A new jump_flag_i reloads the counter.
  - bus_req_i is ignored until back in RUN.
- DRAIN:
  - Counter decrements; at 1 → OWN.
  - jump_flag_i is still forwarded. A jump restarts the drain count, and hold_flag_o is Hold_Id that cycle.
  - bus_req_i dropping in DRAIN → RUN, no grant.
- OWN:
  - bus_gnt_o=1 (registered: high for every cycle in OWN).
  - bus_req_i low → RUN; bus_gnt_o is low from the next cycle.
- stall_cnt_o:
  - Increments by 1 every cycle with hold_flag_o != 0 and wraps 0xFFFFFFFF → 0.
  - cnt_clr_i has priority over increment: the counter reads 0 the next cycle.

## Timing
- Reset (rst=0, any time, including mid-DRAIN/OWN/JFLUSH), effective immediately:
  - State RUN, counters 0.
  - bus_gnt_o=0, stall_cnt_o=0.
  - hold_flag_o/jump outputs remain combinational functions of the inputs (0 with idle inputs).
- Latency:
  - Jump/ex/clint/load-use → hold_flag_o: 0 cycles.
  - bus_req_i rise → bus_gnt_o rise: DRAIN_CYCLES+1 cycles when uninterrupted.
  - bus_req_i fall → bus_gnt_o fall: 1 cycle.
- Hold_Pc is asserted from the first DRAIN cycle through the last OWN cycle, with no gap.
- Simultaneous hold_ex_i and bus_req_i in RUN: stay in RUN until hold_ex_i drops.

## Test plan
- Idle, then jump_flag_i=1 for one cycle with jump_addr_i=0x0000_0100, JUMP_FLUSH_CYCLES=1 → jump_addr_o=0x100 that cycle; hold_flag_o=3 for exactly 2 cycles; stall_cnt_o=2.
- ex_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 → hold_flag_o=3 same cycle. Same stimulus with ex_rd_i=0 → hold_flag_o=0.
- bus_req_i held high, DRAIN_CYCLES=2 → hold_flag_o=1 from cycle 1; bus_gnt_o=1 at cycle 3. Drop bus_req_i at cycle 6 → bus_gnt_o=0 and hold_flag_o=0 at cycle 7.
- bus_req_i and jump_flag_i rise in the same RUN cycle → JFLUSH first (hold=3 for 2 cycles), then DRAIN; grant 3 cycles after returning to RUN.
- Assert rst=0 mid-OWN → bus_gnt_o=0 immediately; after release, state RUN and stall_cnt_o=0.
- Force stall_cnt_o to 0xFFFFFFFF via a hold run with the counter preloaded (backdoor), then one more hold cycle → 0. cnt_clr_i together with hold → 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hold/flush scheduler for the pc_reg -> if_id -> id_ex -> ex pipeline, plus
// external-master bus arbitration and a free-running stall-cycle counter.
module pipe_ctrl #(
    parameter int JUMP_FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        bus_req_i,
    input  logic        cnt_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_gnt_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_JFLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_OWN    = 2'd3;

    localparam logic [2:0] JF_LOAD = 3'(JUMP_FLUSH_CYCLES);
    localparam logic [2:0] DR_LOAD = 3'(DRAIN_CYCLES);

    logic [1:0]  state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] stall_cnt_reg;
    logic        load_use;
    logic        hold_id_req;
    logic        hold_pc_req;

    assign jump_flag_o = jump_flag_i;
    assign jump_addr_o = jump_addr_i;

    assign load_use = ex_load_i && (ex_rd_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    assign hold_id_req = jump_flag_i || (state_reg == ST_JFLUSH) || hold_ex_i ||
                         hold_clint_i || load_use;
    assign hold_pc_req = (state_reg == ST_DRAIN) || (state_reg == ST_OWN);

    // Hold codes are ordered by severity, so the highest active request wins.
    assign hold_flag_o = hold_id_req ? HOLD_ID : (hold_pc_req ? HOLD_PC : HOLD_NONE);

    assign bus_gnt_o   = (state_reg == ST_OWN);
    assign stall_cnt_o = stall_cnt_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (jump_flag_i) begin
                    if (JF_LOAD != 3'd0) begin
                        state_next = ST_JFLUSH;
                        cnt_next   = JF_LOAD;
                    end
                end else if (bus_req_i && !hold_ex_i) begin
                    state_next = ST_DRAIN;
                    cnt_next   = DR_LOAD;
                end
            end
            ST_JFLUSH: begin
                if (jump_flag_i) begin
                    cnt_next = JF_LOAD;
                end else if (cnt_reg == 3'd1) begin
                    state_next = ST_RUN;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_DRAIN: begin
                if (!bus_req_i) begin
                    // Request withdrawn: a jump seen in the same cycle still gets its flush window.
                    if (jump_flag_i && (JF_LOAD != 3'd0)) begin
                        state_next = ST_JFLUSH;
                        cnt_next   = JF_LOAD;
                    end else begin
                        state_next = ST_RUN;
                        cnt_next   = 3'd0;
                    end
                end else if (jump_flag_i) begin
                    cnt_next = DR_LOAD;
                end else if (cnt_reg == 3'd1) begin
                    state_next = ST_OWN;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_OWN: begin
                if (!bus_req_i) begin
                    if (jump_flag_i && (JF_LOAD != 3'd0)) begin
                        state_next = ST_JFLUSH;
                        cnt_next   = JF_LOAD;
                    end else begin
                        state_next = ST_RUN;
                        cnt_next   = 3'd0;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            cnt_reg       <= 3'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (cnt_clr_i) begin
                stall_cnt_reg <= 32'd0;
            end else if (hold_flag_o != HOLD_NONE) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues the expected outputs for each
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_clint_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        bus_req_i;
    logic        cnt_clr_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        bus_gnt_o;
    logic [31:0] stall_cnt_o;

    pipe_ctrl #(
        .JUMP_FLUSH_CYCLES(1),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i),
        .hold_clint_i(hold_clint_i),
        .ex_load_i(ex_load_i),
        .ex_rd_i(ex_rd_i),
        .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i),
        .id_rs2_used_i(id_rs2_used_i),
        .bus_req_i(bus_req_i),
        .cnt_clr_i(cnt_clr_i),
        .hold_flag_o(hold_flag_o),
        .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o),
        .bus_gnt_o(bus_gnt_o),
        .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        string       name;
        logic [2:0]  hold;
        logic        gnt;
        logic [31:0] cnt;
        bit          chk_j;
        logic [31:0] jaddr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (hold_flag_o !== e.hold) begin
                bad++;
                $display("FAIL %s hold_flag: got %0d expected %0d", e.name, hold_flag_o, e.hold);
            end
            total++;
            if (bus_gnt_o !== e.gnt) begin
                bad++;
                $display("FAIL %s bus_gnt: got %0d expected %0d", e.name, bus_gnt_o, e.gnt);
            end
            total++;
            if (stall_cnt_o !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt: got %h expected %h", e.name, stall_cnt_o, e.cnt);
            end
            if (e.chk_j) begin
                total++;
                if (jump_flag_o !== 1'b1 || jump_addr_o !== e.jaddr) begin
                    bad++;
                    $display("FAIL %s jump: got flag=%0d addr=%h expected flag=1 addr=%h",
                             e.name, jump_flag_o, jump_addr_o, e.jaddr);
                end
            end
            $display("txn %-12s hold=%0d gnt=%0d cnt=%h", e.name, hold_flag_o, bus_gnt_o, stall_cnt_o);
        end
    end

    task automatic idle();
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'd0;
        hold_ex_i     = 1'b0;
        hold_clint_i  = 1'b0;
        ex_load_i     = 1'b0;
        ex_rd_i       = 5'd0;
        id_rs1_i      = 5'd0;
        id_rs2_i      = 5'd0;
        id_rs1_used_i = 1'b0;
        id_rs2_used_i = 1'b0;
        bus_req_i     = 1'b0;
        cnt_clr_i     = 1'b0;
    endtask

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic expect_cyc(input string nm, input logic [2:0] h, input logic g,
                              input logic [31:0] c, input bit cj = 1'b0,
                              input logic [31:0] ja = 32'd0);
        exp_t e;
        e.name  = nm;
        e.hold  = h;
        e.gnt   = g;
        e.cnt   = c;
        e.chk_j = cj;
        e.jaddr = ja;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_cyc("reset", 3'd0, 1'b0, 32'd0);
        rst = 1'b1;

        // Single jump: Hold_Id for the jump cycle plus one flush cycle.
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
        expect_cyc("jump", 3'd3, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
        idle();
        expect_cyc("jflush", 3'd3, 1'b0, 32'd1);
        expect_cyc("jdone", 3'd0, 1'b0, 32'd2);
        expect_cyc("jidle", 3'd0, 1'b0, 32'd2);

        // Load-use detection on rs2 / rs1, rd=0 guard, used-flag and load-flag gating.
        ex_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1'b1;
        expect_cyc("lu_rs2", 3'd3, 1'b0, 32'd2);
        ex_rd_i = 5'd0; id_rs2_i = 5'd0;
        expect_cyc("lu_rd0", 3'd0, 1'b0, 32'd3);
        idle();
        ex_load_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_used_i = 1'b1;
        expect_cyc("lu_rs1", 3'd3, 1'b0, 32'd3);
        id_rs1_used_i = 1'b0;
        expect_cyc("lu_unused", 3'd0, 1'b0, 32'd4);
        id_rs1_used_i = 1'b1; ex_load_i = 1'b0;
        expect_cyc("lu_noload", 3'd0, 1'b0, 32'd4);
        idle();
        hold_ex_i = 1'b1;
        expect_cyc("hold_ex", 3'd3, 1'b0, 32'd4);
        idle(); hold_clint_i = 1'b1;
        expect_cyc("hold_clint", 3'd3, 1'b0, 32'd5);
        idle();
        expect_cyc("idle", 3'd0, 1'b0, 32'd6);

        // Uninterrupted bus request: grant DRAIN_CYCLES+1 cycles after rise.
        bus_req_i = 1'b1;
        expect_cyc("bus_c0", 3'd0, 1'b0, 32'd6);
        expect_cyc("bus_c1", 3'd1, 1'b0, 32'd6);
        expect_cyc("bus_c2", 3'd1, 1'b0, 32'd7);
        expect_cyc("bus_c3", 3'd1, 1'b1, 32'd8);
        expect_cyc("bus_c4", 3'd1, 1'b1, 32'd9);
        expect_cyc("bus_c5", 3'd1, 1'b1, 32'd10);
        bus_req_i = 1'b0;
        expect_cyc("bus_c6", 3'd1, 1'b1, 32'd11);
        expect_cyc("bus_c7", 3'd0, 1'b0, 32'd12);
        expect_cyc("bus_c8", 3'd0, 1'b0, 32'd12);

        // hold_ex blocks the drain until it drops.
        bus_req_i = 1'b1; hold_ex_i = 1'b1;
        expect_cyc("exbus_c0", 3'd3, 1'b0, 32'd12);
        hold_ex_i = 1'b0;
        expect_cyc("exbus_c1", 3'd0, 1'b0, 32'd13);
        expect_cyc("exbus_c2", 3'd1, 1'b0, 32'd13);
        expect_cyc("exbus_c3", 3'd1, 1'b0, 32'd14);
        expect_cyc("exbus_c4", 3'd1, 1'b1, 32'd15);
        bus_req_i = 1'b0;
        expect_cyc("exbus_c5", 3'd1, 1'b1, 32'd16);
        expect_cyc("exbus_c6", 3'd0, 1'b0, 32'd17);

        // Jump and bus request together: flush first, then drain.
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_2000; bus_req_i = 1'b1;
        expect_cyc("jbus_c0", 3'd3, 1'b0, 32'd17, 1'b1, 32'h0000_2000);
        jump_flag_i = 1'b0; jump_addr_i = 32'd0;
        expect_cyc("jbus_c1", 3'd3, 1'b0, 32'd18);
        expect_cyc("jbus_c2", 3'd0, 1'b0, 32'd19);
        expect_cyc("jbus_c3", 3'd1, 1'b0, 32'd19);
        expect_cyc("jbus_c4", 3'd1, 1'b0, 32'd20);
        expect_cyc("jbus_c5", 3'd1, 1'b1, 32'd21);
        bus_req_i = 1'b0;
        expect_cyc("jbus_c6", 3'd1, 1'b1, 32'd22);
        expect_cyc("jbus_c7", 3'd0, 1'b0, 32'd23);

        // Jump during DRAIN restarts the drain count.
        bus_req_i = 1'b1;
        expect_cyc("djmp_c0", 3'd0, 1'b0, 32'd23);
        expect_cyc("djmp_c1", 3'd1, 1'b0, 32'd23);
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0440;
        expect_cyc("djmp_c2", 3'd3, 1'b0, 32'd24, 1'b1, 32'h0000_0440);
        jump_flag_i = 1'b0; jump_addr_i = 32'd0;
        expect_cyc("djmp_c3", 3'd1, 1'b0, 32'd25);
        expect_cyc("djmp_c4", 3'd1, 1'b0, 32'd26);
        expect_cyc("djmp_c5", 3'd1, 1'b1, 32'd27);
        bus_req_i = 1'b0;
        expect_cyc("djmp_c6", 3'd1, 1'b1, 32'd28);
        expect_cyc("djmp_c7", 3'd0, 1'b0, 32'd29);

        // Request dropped mid-drain: back to RUN with no grant.
        bus_req_i = 1'b1;
        expect_cyc("abort_c0", 3'd0, 1'b0, 32'd29);
        bus_req_i = 1'b0;
        expect_cyc("abort_c1", 3'd1, 1'b0, 32'd29);
        expect_cyc("abort_c2", 3'd0, 1'b0, 32'd30);
        expect_cyc("abort_c3", 3'd0, 1'b0, 32'd30);

        // Reset asserted while the bus is owned.
        bus_req_i = 1'b1;
        expect_cyc("rown_c0", 3'd0, 1'b0, 32'd30);
        expect_cyc("rown_c1", 3'd1, 1'b0, 32'd30);
        expect_cyc("rown_c2", 3'd1, 1'b0, 32'd31);
        expect_cyc("rown_c3", 3'd1, 1'b1, 32'd32);
        rst = 1'b0;
        expect_cyc("rown_rst", 3'd0, 1'b0, 32'd0);
        bus_req_i = 1'b0;
        expect_cyc("rown_hold", 3'd0, 1'b0, 32'd0);
        rst = 1'b1;
        expect_cyc("rown_post", 3'd0, 1'b0, 32'd0);

        // Back-to-back jumps keep the flush window open.
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0800;
        expect_cyc("jj_c0", 3'd3, 1'b0, 32'd0, 1'b1, 32'h0000_0800);
        jump_addr_i = 32'h0000_0900;
        expect_cyc("jj_c1", 3'd3, 1'b0, 32'd1, 1'b1, 32'h0000_0900);
        idle();
        expect_cyc("jj_c2", 3'd3, 1'b0, 32'd2);
        expect_cyc("jj_c3", 3'd0, 1'b0, 32'd3);

        // Wrap: preload near the top, then hold.
        dut.stall_cnt_reg = 32'hFFFF_FFFE;
        hold_clint_i = 1'b1;
        expect_cyc("wrap_c0", 3'd3, 1'b0, 32'hFFFF_FFFE);
        expect_cyc("wrap_c1", 3'd3, 1'b0, 32'hFFFF_FFFF);
        idle();
        expect_cyc("wrap_c2", 3'd0, 1'b0, 32'd0);

        // Clear beats increment.
        hold_clint_i = 1'b1;
        expect_cyc("clr_c0", 3'd3, 1'b0, 32'd0);
        cnt_clr_i = 1'b1;
        expect_cyc("clr_c1", 3'd3, 1'b0, 32'd1);
        idle();
        expect_cyc("clr_c2", 3'd0, 1'b0, 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
